// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// vector count and the hold-counter width helper.
package truth_sweep_pkg;

  // A 2-input circuit has four input combinations {A,B} = 0..3.
  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Width of the hold counter: clog2(hold), never narrower than one bit
  // so that HOLD_CYCLES=1 still has a legal (constant-zero) counter.
  function automatic int cnt_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold counter for one input vector. Counts 0..HOLD_CYCLES-1 while tick is
// high and wraps to 0 on its own after the last count, so back-to-back
// vectors need no reload and there is no idle gap between them.
module hold_timer
  import truth_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = cnt_width(HOLD_CYCLES)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  // expire marks the edge at which the current vector is sampled.
  assign expire = (cnt == LAST);

  // Counter: load clears it, tick advances it and wraps at LAST.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= expire ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives {A,B} through 00,01,10,11, holding each vector
// for HOLD_CYCLES cycles, captures Q at the end of each hold into TABLE and
// compares the captured table against the EXPECT value latched at START.
//
// Handshake: START is a level sampled on a rising edge and is accepted only
// in IDLE; there is no ready signal and no queuing, so a START seen in DRIVE
// or FIN is dropped. DONE pulses for exactly one cycle (FIN) and PASS,
// TABLE and MISMATCH stay valid from then until the next accepted START.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] EXPECT,
  input  logic       Q,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] TABLE,
  output logic [3:0] MISMATCH,
  output state_t     dbg_state
);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] exp_lat;
  logic [3:0] captured;
  logic       load;
  logic       tick;
  logic       expire;

  // The timer restarts on an accepted START and runs only while driving.
  assign load      = (state == IDLE) && START;
  assign tick      = (state == DRIVE);
  assign dbg_state = state;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (load),
    .tick  (tick),
    .expire(expire)
  );

  // Table as it will look after this cycle's sample, so PASS/MISMATCH can
  // be registered on the same edge as the last capture and be valid in FIN.
  always_comb begin
    captured      = TABLE;
    captured[idx] = Q;
  end

  // Sweep FSM with registered outputs and capture/compare logic.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= 2'd0;
      exp_lat  <= 4'd0;
      A        <= 1'b0;
      B        <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      TABLE    <= 4'd0;
      MISMATCH <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          A    <= 1'b0;
          B    <= 1'b0;
          DONE <= 1'b0;
          BUSY <= 1'b0;
          if (START) begin
            // EXPECT is latched here so later changes cannot affect results.
            exp_lat  <= EXPECT;
            TABLE    <= 4'd0;
            PASS     <= 1'b0;
            MISMATCH <= 4'd0;
            idx      <= 2'd0;
            BUSY     <= 1'b1;
            state    <= DRIVE;
          end
        end

        DRIVE: begin
          if (expire) begin
            TABLE[idx] <= Q;
            if (idx == 2'(NUM_VECTORS - 1)) begin
              PASS     <= (captured == exp_lat);
              MISMATCH <= captured ^ exp_lat;
              A        <= 1'b0;
              B        <= 1'b0;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              state    <= FIN;
            end else begin
              idx    <= idx + 2'd1;
              {A, B} <= idx + 2'd1;
            end
          end
        end

        FIN: begin
          // START is ignored here; the sweeper always passes through IDLE.
          DONE  <= 1'b0;
          idx   <= 2'd0;
          state <= IDLE;
        end

        default: begin
          A     <= 1'b0;
          B     <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          idx   <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with the default hold
// of 4 cycles and one with a hold of 1, each driving a behavioural 2-input
// circuit model selected by the bench.
module tb_truth_table_sweeper;
  import truth_sweep_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index 0: hold 4, index 1: hold 1) --------
  logic       st     [2];
  logic [3:0] ex     [2];
  int         mode   [2];
  logic       q_i    [2];
  logic       a_o    [2];
  logic       b_o    [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [3:0] table_o[2];
  logic [3:0] mism_o [2];
  state_t     state_o[2];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [2];

  logic [1:0] exp_q[$];

  // Circuit under control: 0 = AND, 1 = XOR, 2 = NAND.
  function automatic logic model(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return a ^ b;
      2:       return ~(a & b);
      default: return 1'b0;
    endcase
  endfunction

  assign q_i[0] = model(mode[0], a_o[0], b_o[0]);
  assign q_i[1] = model(mode[1], a_o[1], b_o[1]);

  truth_table_sweeper #(.HOLD_CYCLES(4)) dut_h4 (
    .CLK(clk), .RST_N(rst_n), .START(st[0]), .EXPECT(ex[0]), .Q(q_i[0]),
    .A(a_o[0]), .B(b_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
    .PASS(pass_o[0]), .TABLE(table_o[0]), .MISMATCH(mism_o[0]),
    .dbg_state(state_o[0])
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) dut_h1 (
    .CLK(clk), .RST_N(rst_n), .START(st[1]), .EXPECT(ex[1]), .Q(q_i[1]),
    .A(a_o[1]), .B(b_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
    .PASS(pass_o[1]), .TABLE(table_o[1]), .MISMATCH(mism_o[1]),
    .dbg_state(state_o[1])
  );

  // DONE pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done_o[0] === 1'b1) done_cnt[0]++;
    if (done_o[1] === 1'b1) done_cnt[1]++;
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one complete sweep ----------------
  // Starts in a cycle where the instance is idle. Returns one cycle after
  // FIN, i.e. with the instance back in IDLE.
  task automatic run_sweep(input int s, input int hc, input logic [3:0] e,
                           input int m, input logic [3:0] exp_tab, input bit pulse);
    st[s]   = 1'b1;
    ex[s]   = e;
    mode[s] = m;
    tick1();                      // accepting edge 0
    st[s] = 1'b0;
    ex[s] = ~e;                   // must not affect the result
    for (int i = 0; i < NUM_VECTORS; i++)
      for (int j = 0; j < hc; j++) exp_q.push_back(2'(i));
    for (int k = 1; k <= NUM_VECTORS * hc; k++) begin
      check_eq("busy_drive", 32'(busy_o[s]), 32'd1);
      check_eq("done_early", 32'(done_o[s]), 32'd0);
      check_eq("ab_seq", 32'({a_o[s], b_o[s]}), 32'(exp_q.pop_front()));
      st[s] = pulse && (k == 3);
      tick1();
    end
    // Cycle 4*hc+1: FIN
    check_eq("done_fin", 32'(done_o[s]), 32'd1);
    check_eq("busy_fin", 32'(busy_o[s]), 32'd0);
    check_eq("ab_fin", 32'({a_o[s], b_o[s]}), 32'd0);
    check_eq("table", 32'(table_o[s]), 32'(exp_tab));
    check_eq("pass", 32'(pass_o[s]), 32'(exp_tab == e));
    check_eq("mismatch", 32'(mism_o[s]), 32'(exp_tab ^ e));
    st[s] = pulse;                // a START during FIN must be dropped
    tick1();
    st[s] = 1'b0;
    check_eq("done_after", 32'(done_o[s]), 32'd0);
    check_eq("busy_after", 32'(busy_o[s]), 32'd0);
    check_eq("state_idle", 32'(state_o[s]), 32'(IDLE));
    check_eq("table_hold", 32'(table_o[s]), 32'(exp_tab));
    check_eq("pass_hold", 32'(pass_o[s]), 32'(exp_tab == e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      st[s] = 1'b0; ex[s] = 4'd0; mode[s] = 0; done_cnt[s] = 0;
    end
    tick1();
    tick1();
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_ab", 32'({a_o[s], b_o[s]}), 32'd0);
      check_eq("rst_busy", 32'(busy_o[s]), 32'd0);
      check_eq("rst_done", 32'(done_o[s]), 32'd0);
      check_eq("rst_pass", 32'(pass_o[s]), 32'd0);
      check_eq("rst_table", 32'(table_o[s]), 32'd0);
      check_eq("rst_mism", 32'(mism_o[s]), 32'd0);
      check_eq("rst_state", 32'(state_o[s]), 32'(IDLE));
    end
    rst_n = 1'b1;
    tick1();

    // AND circuit, EXPECT=1000: passes.
    run_sweep(0, 4, 4'b1000, 0, 4'b1000, 1'b0);
    check_eq("done_cnt_and", 32'(done_cnt[0]), 32'd1);

    // XOR circuit, EXPECT=1000, extra STARTs in cycles 3 and 17.
    run_sweep(0, 4, 4'b1000, 1, 4'b0110, 1'b1);
    tick1();
    check_eq("busy_no_requeue", 32'(busy_o[0]), 32'd0);
    check_eq("done_cnt_xor", 32'(done_cnt[0]), 32'd2);

    // Reset in cycle 6 of a NAND sweep.
    st[0] = 1'b1; ex[0] = 4'b0111; mode[0] = 2;
    tick1();                      // edge 0
    st[0] = 1'b0;
    repeat (5) tick1();           // now in cycle 6
    check_eq("nand_table_pre", 32'(table_o[0]), 32'b0001);
    check_eq("nand_ab_pre", 32'({a_o[0], b_o[0]}), 32'b01);
    rst_n = 1'b0;
    st[0] = 1'b1;                 // ignored while in reset
    tick1();
    check_eq("abort_ab", 32'({a_o[0], b_o[0]}), 32'd0);
    check_eq("abort_busy", 32'(busy_o[0]), 32'd0);
    check_eq("abort_table", 32'(table_o[0]), 32'd0);
    check_eq("abort_done", 32'(done_o[0]), 32'd0);
    check_eq("abort_state", 32'(state_o[0]), 32'(IDLE));
    tick1();
    check_eq("rst_start_ign", 32'(busy_o[0]), 32'd0);
    rst_n = 1'b1;
    st[0] = 1'b0;
    repeat (20) tick1();
    check_eq("abort_busy_late", 32'(busy_o[0]), 32'd0);
    check_eq("abort_no_done", 32'(done_cnt[0]), 32'd2);

    // Hold of 1: two back-to-back AND sweeps, second START right after FIN.
    run_sweep(1, 1, 4'b1000, 0, 4'b1000, 1'b0);
    run_sweep(1, 1, 4'b1000, 0, 4'b1000, 1'b0);
    check_eq("done_cnt_h1", 32'(done_cnt[1]), 32'd2);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles each input vector is held before Q is sampled; legal range 1..256.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  sweep request; accepted only in IDLE.
REQ-005 EXPECT  input  4  expected truth table; bit i = expected Q for {A,B}=i (i = 2*A+B).
REQ-006 Q  input  1  output of the 2-input circuit under control.
REQ-007 A  output  1  drive to circuit input A.
REQ-008 B  output  1  drive to circuit input B.
REQ-009 BUSY  output  1  high while a sweep is in progress.
REQ-010 DONE  output  1  one-cycle pulse at sweep completion.
REQ-011 PASS  output  1  captured table equals latched EXPECT; valid from DONE until next accepted START.
REQ-012 TABLE  output  4  captured Q per vector index.
REQ-013 MISMATCH  output  4  TABLE XOR latched EXPECT.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, FIN.
REQ-015 IDLE: A=B=0, BUSY=0, DONE=0; START=1 at an edge SHALL latch EXPECT, clear TABLE/PASS/MISMATCH, set idx=0, cnt=0, and enter DRIVE.
REQ-016 DRIVE: {A,B} SHALL equal idx (registered outputs); BUSY=1; cnt increments each cycle from 0.
REQ-017 At the edge where cnt==HOLD_CYCLES-1, Q SHALL be written to TABLE[idx]; then if idx==3 go to FIN, else idx+1 and cnt=0.
REQ-018 Each vector SHALL be driven for exactly HOLD_CYCLES cycles; DRIVE lasts 4*HOLD_CYCLES cycles.
REQ-019 FIN: DONE=1 for exactly one cycle, BUSY=0, A=B=0; PASS and MISMATCH SHALL be valid this cycle; next state IDLE.
REQ-020 Latency: START accepted at edge 0 -> DONE high in cycle 4*HOLD_CYCLES+1 (17 for default).
REQ-021 START SHALL be ignored in DRIVE and FIN; no queuing.
REQ-022 TABLE, PASS, MISMATCH SHALL hold their values in IDLE until the next accepted START.
REQ-023 HOLD_CYCLES=1 SHALL sample every cycle with no idle gap between vectors.
REQ-024 cnt width SHALL be clog2(HOLD_CYCLES) with minimum 1; cnt never exceeds HOLD_CYCLES-1.
REQ-025 Changes on EXPECT after START acceptance SHALL not affect PASS/MISMATCH.

Reset
REQ-026 RST_N=0 at an edge SHALL force IDLE, A=B=0, BUSY=0, DONE=0, PASS=0, TABLE=0, MISMATCH=0, idx=0, cnt=0.
REQ-027 Reset mid-sweep SHALL abort with no DONE pulse; START is ignored while RST_N=0.

Structure
REQ-028 Package truth_sweep_pkg SHALL hold the state enum and NUM_VECTORS=4.
REQ-029 Hold counter SHALL be sub-module hold_timer (load, tick, expire output); FSM and capture logic stay in the top.

Verification
REQ-030 AND model, EXPECT=4'b1000, default HOLD -> DONE in cycle 17, TABLE=1000, PASS=1, MISMATCH=0000.
REQ-031 XOR model, EXPECT=4'b1000 -> TABLE=0110, PASS=0, MISMATCH=1110.
REQ-032 START pulsed again in cycles 3 and 17 -> ignored; exactly one DONE; {A,B} sequence 00,01,10,11 each 4 cycles.
REQ-033 RST_N=0 in cycle 6 of sweep -> next edge A=B=0, BUSY=0, TABLE=0; no DONE ever asserted.
REQ-034 HOLD_CYCLES=1, AND model -> DONE in cycle 5, PASS=1; START in cycle after DONE accepted and second sweep identical.
